// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared frame, address and state definitions for the SPI register peripheral
package spi_reg_pkg;
  localparam int FRAME_BITS = 16;
  localparam int NUM_REGS = 5;
  localparam int ADDR_EN_OUT_LO = 0;
  localparam int ADDR_EN_OUT_HI = 1;
  localparam int ADDR_EN_PWM_LO = 2;
  localparam int ADDR_EN_PWM_HI = 3;
  localparam int ADDR_DUTY = 4;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchroniser with edge pulses derived from the synchronised level
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic prev_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end
  assign lvl_o = sync_q[STAGES-1];
  assign rise_o = lvl_o & ~prev_q;
  assign fall_o = ~lvl_o & prev_q;
endmodule

// File: rtl/spi_reg_peripheral.sv
// spi_reg_peripheral: write-only SPI mode-0 slave sampled in the clk domain, driving five control registers
module spi_reg_peripheral
  import spi_reg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe,
  output logic       frame_err
);
  logic sclk_lvl, sclk_rise, sclk_fall, copi_lvl, copi_rise, copi_fall, ncs_lvl, ncs_rise, ncs_fall;
  sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (.clk(clk), .rst(rst), .d_i(sclk), .lvl_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall));
  sync_edge #(.STAGES(SYNC_STAGES)) u_copi (.clk(clk), .rst(rst), .d_i(copi), .lvl_o(copi_lvl), .rise_o(copi_rise), .fall_o(copi_fall));
  sync_edge #(.STAGES(SYNC_STAGES)) u_ncs (.clk(clk), .rst(rst), .d_i(ncs), .lvl_o(ncs_lvl), .rise_o(ncs_rise), .fall_o(ncs_fall));
  logic unused;
  assign unused = ^{sclk_lvl, sclk_fall, copi_rise, copi_fall, ncs_lvl};
  state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic [7:0] regs_q [NUM_REGS];
  logic wr_d, err_d, full;
  assign full = cnt_q == 5'(FRAME_BITS);
  assign wr_d = state_q == COMMIT && full && sr_q[15] && sr_q[14:8] <= 7'(MAX_ADDR);
  assign err_d = state_q == COMMIT && !full;
  // The ncs edges take priority, so an sclk edge coinciding with frame start is dropped.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sr_d = sr_q;
    case (state_q)
      IDLE: if (ncs_fall) begin
        state_d = SHIFT;
        cnt_d = '0;
        sr_d = '0;
      end
      SHIFT: if (ncs_rise) state_d = COMMIT;
        else if (sclk_rise) begin
          sr_d = {sr_q[FRAME_BITS-2:0], copi_lvl};
          cnt_d = cnt_q == 5'(FRAME_BITS + 1) ? cnt_q : cnt_q + 5'd1;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sr_q <= '0;
      regs_q <= '{default: '0};
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sr_q <= sr_d;
      wr_strobe <= wr_d;
      frame_err <= err_d;
      for (int i = 0; i < NUM_REGS; i++)
        if (wr_d && sr_q[14:8] == 7'(i)) regs_q[i] <= sr_q[7:0];
    end
  end
  assign en_reg_out_7_0 = regs_q[ADDR_EN_OUT_LO];
  assign en_reg_out_15_8 = regs_q[ADDR_EN_OUT_HI];
  assign en_reg_pwm_7_0 = regs_q[ADDR_EN_PWM_LO];
  assign en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_HI];
  assign pwm_duty_cycle = regs_q[ADDR_DUTY];
endmodule
